// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the memory port arbiter.
package mem_arb_pkg;

   // Widest requester set the search helper supports, and its index width.
   localparam int RR_MAX_REQ = 8;
   localparam int RR_IDX_W   = 3;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of valid, searching ptr, ptr+1, ... modulo num_req.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                        input logic [RR_IDX_W-1:0]   ptr,
                                        input int                    num_req);
      rr_pick_t res;
      int       k;
      res.found = 1'b0;
      res.idx   = {RR_IDX_W{1'b0}};
      for (int i = 0; i < RR_MAX_REQ; i++) begin
         if (i < num_req) begin
            k = (int'(ptr) + i) % num_req;
            if (!res.found && valid[k]) begin
               res.found = 1'b1;
               res.idx   = RR_IDX_W'(k);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Pure-combinational rotating priority encoder; reusable by any arbiter.
module rr_grant
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               gnt_found,
   output logic [IDX_W-1:0]   gnt_idx
);

   rr_pick_t pick_s;

   // Search from rr_ptr upward and report the first valid requester.
   always_comb begin
      pick_s    = rr_pick(RR_MAX_REQ'(req_valid), RR_IDX_W'(rr_ptr), NUM_REQ);
      gnt_found = pick_s.found;
      gnt_idx   = IDX_W'(pick_s.idx);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle read latency)
// between NUM_REQ requesters, with an optional bounded burst lock.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ-1:0]            req_we_i,
   input  logic [NUM_REQ-1:0]            req_lock_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
   output logic                          mem_wr_en_o,
   output logic                          mem_rd_en_o,
   output logic [ADDR_WIDTH-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0]         mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

   localparam int                 IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int                 CNT_W      = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
   localparam bit                 LOCK_EN    = (MAX_BURST > 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_e             state_r, state_nxt_s;
   logic [IDX_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
   logic [IDX_W-1:0]       owner_r, owner_nxt_s;
   logic [CNT_W-1:0]       burst_cnt_r, burst_cnt_nxt_s;
   logic [NUM_REQ-1:0]     rsp_valid_r, rsp_valid_nxt_s;

   logic                   rr_found_s;
   logic [IDX_W-1:0]       rr_idx_s;
   logic                   grant_s;
   logic [IDX_W-1:0]       sel_s;
   logic [NUM_REQ-1:0]     sel_onehot_s;
   logic                   sel_we_s;
   logic                   sel_lock_s;
   logic [ADDR_WIDTH-1:0]  sel_addr_s;
   logic [DATA_WIDTH-1:0]  sel_wdata_s;

   rr_grant #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_grant (
      .req_valid (req_valid_i),
      .rr_ptr    (rr_ptr_r),
      .gnt_found (rr_found_s),
      .gnt_idx   (rr_idx_s)
   );

   // Decide who (if anyone) owns the port this cycle; nobody while in reset.
   always_comb begin
      grant_s = 1'b0;
      sel_s   = rr_idx_s;
      if (reset) begin
         grant_s = 1'b0;
      end else if (state_r == LOCKED) begin
         sel_s   = owner_r;
         grant_s = req_valid_i[owner_r];
      end else begin
         grant_s = rr_found_s;
      end
   end

   assign sel_onehot_s = ONE_HOT0 << sel_s;
   assign sel_we_s     = req_we_i[sel_s];
   assign sel_lock_s   = req_lock_i[sel_s];
   assign sel_addr_s   = req_addr_i[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_wdata_s  = req_wdata_i[sel_s*DATA_WIDTH +: DATA_WIDTH];

   // Route the granted requester onto the memory pins; idle pins are all zero.
   always_comb begin
      req_ready_o = {NUM_REQ{1'b0}};
      mem_wr_en_o = 1'b0;
      mem_rd_en_o = 1'b0;
      mem_addr_o  = {ADDR_WIDTH{1'b0}};
      mem_wdata_o = {DATA_WIDTH{1'b0}};
      if (grant_s) begin
         req_ready_o = sel_onehot_s;
         mem_wr_en_o = sel_we_s;
         mem_rd_en_o = !sel_we_s;
         mem_addr_o  = sel_addr_s;
         mem_wdata_o = sel_wdata_s;
      end else begin
         req_ready_o = {NUM_REQ{1'b0}};
      end
   end

   // Next arbitration state, round-robin pointer, burst count and response tag.
   always_comb begin
      state_nxt_s     = state_r;
      rr_ptr_nxt_s    = rr_ptr_r;
      owner_nxt_s     = owner_r;
      burst_cnt_nxt_s = burst_cnt_r;
      if (grant_s && !sel_we_s) begin
         rsp_valid_nxt_s = sel_onehot_s;
      end else begin
         rsp_valid_nxt_s = {NUM_REQ{1'b0}};
      end
      case (state_r)
         ARB: begin
            if (grant_s) begin
               rr_ptr_nxt_s = (sel_s == LAST_IDX) ? {IDX_W{1'b0}} : (sel_s + IDX_W'(1'b1));
               if (LOCK_EN && sel_lock_s) begin
                  state_nxt_s     = LOCKED;
                  owner_nxt_s     = sel_s;
                  burst_cnt_nxt_s = CNT_W'(1'b1);
               end else begin
                  state_nxt_s     = ARB;
                  burst_cnt_nxt_s = {CNT_W{1'b0}};
               end
            end else begin
               state_nxt_s = ARB;
            end
         end
         LOCKED: begin
            // rr_ptr already points past the owner and is left alone here.
            if (grant_s) begin
               if (!sel_lock_s || (burst_cnt_r >= BURST_LAST)) begin
                  state_nxt_s     = ARB;
                  burst_cnt_nxt_s = {CNT_W{1'b0}};
               end else begin
                  state_nxt_s     = LOCKED;
                  burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1'b1);
               end
            end else begin
               // Owner went idle: this cycle releases the lock without a grant.
               state_nxt_s     = ARB;
               burst_cnt_nxt_s = {CNT_W{1'b0}};
            end
         end
         default: begin
            state_nxt_s     = ARB;
            burst_cnt_nxt_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, pointer, burst counter and one-hot read-return register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ARB;
         rr_ptr_r    <= {IDX_W{1'b0}};
         owner_r     <= {IDX_W{1'b0}};
         burst_cnt_r <= {CNT_W{1'b0}};
         rsp_valid_r <= {NUM_REQ{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         rr_ptr_r    <= rr_ptr_nxt_s;
         owner_r     <= owner_nxt_s;
         burst_cnt_r <= burst_cnt_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
      end
   end

   assign rsp_valid_o = rsp_valid_r;
   assign rsp_rdata_o = mem_rdata_i;

endmodule
